// File: rtl/fifo_pkg.sv
// Shared types and defaults for the single-clock FIFO family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   fifo_mode_e          - read-port flavour: registered output or first-word-fall-through
//   FIFO_DATA_WIDTH_DEF  - default word width
//   FIFO_DEPTH_DEF       - default number of entries
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,   // data_o registered on an accepted read
        FIFO_FWFT = 1'b1    // head word presented combinationally on data_o
    } fifo_mode_e;

    localparam int FIFO_DATA_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF      = 16;

    // Pointer width for a FIFO of the given depth (depth is always >= 2).
    function automatic int fifo_ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer that counts 0..DEPTH-1 and wraps explicitly, so any DEPTH >= 2 works.
// Latency: ptr_o updates on the rising edge after inc_i or clr_i.
// Backpressure: none; the caller only asserts inc_i for accepted transfers.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset (pointer -> 0)
//   clr_i          - synchronous clear to 0, wins over inc_i
//   inc_i          - advance by one, wrapping DEPTH-1 -> 0
//   ptr_o          - current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic                             inc_i,
    output logic [fifo_ptr_width(DEPTH)-1:0] ptr_o
);

    localparam int PW = fifo_ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_d;
    logic [PW-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            // Explicit wrap rather than natural overflow: DEPTH need not be a power of two.
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO, arbitrary depth >= 2, standard or first-word-fall-through read, level and threshold flags.
// Latency: flags/level 1 cycle after the accepting edge; data_o 1 cycle after read (STD) or 1 cycle after write (FWFT).
// Backpressure: writes on full are rejected unless a read is accepted the same cycle; rejects set sticky error flags.
//
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   clr_i                  - synchronous flush: pointers, level, data_o and error flags to 0
//   wr_en_i, data_i        - write request and data
//   rd_en_i                - read / pop request
//   data_o                 - read data (registered in STD, head word in FWFT)
//   full_o, empty_o        - level == DEPTH, level == 0
//   almost_full_o          - level >= AF_THRESH
//   almost_empty_o         - level <= AE_THRESH
//   level_o                - current occupancy
//   overflow_o             - sticky: a write was rejected
//   underflow_o            - sticky: a read was rejected
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int         DEPTH      = FIFO_DEPTH_DEF,
    parameter fifo_mode_e MODE       = FIFO_STD,
    parameter int         AF_THRESH  = DEPTH - 2,
    parameter int         AE_THRESH  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         rd_en_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int PW = fifo_ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic rd_acc;
    logic wr_acc;
    logic rd_do;
    logic wr_do;

    // A full FIFO still takes a write when a read frees the slot in the same
    // cycle; with wr_ptr == rd_ptr the read sees the old slot contents because
    // the memory write only lands at the clock edge.
    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);

    // Flush swallows both requests so no state moves during clr_i.
    assign rd_do = rd_acc && !clr_i;
    assign wr_do = wr_acc && !clr_i;

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (wr_do),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (rd_do),
        .ptr_o  (rd_ptr)
    );

    // ------------------------------------------------------------------
    // Storage: no reset, contents only become visible through rd_ptr after
    // the level says they were written.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] head_dat;

    always_ff @(posedge clk_i) begin
        if (wr_do) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

    assign head_dat = mem_q[rd_ptr];

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    logic [LW-1:0] level_d;
    logic [LW-1:0] level_q;

    always_comb begin
        level_d = level_q;
        if (clr_i) begin
            level_d = '0;
        end else begin
            unique case ({wr_do, rd_do})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Flags come straight off the registered level so they move one cycle
    // after the accepting edge and never glitch on request inputs.
    assign level_o        = level_q;
    assign full_o         = (level_q == LVL_FULL);
    assign empty_o        = (level_q == '0);
    assign almost_full_o  = (level_q >= LVL_AF);
    assign almost_empty_o = (level_q <= LVL_AE);

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic overflow_d;
    logic overflow_q;
    logic underflow_d;
    logic underflow_q;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en_i && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en_i && !rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // ------------------------------------------------------------------
    // Read data port
    // ------------------------------------------------------------------
    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word is shown while anything is stored; zero when empty so
        // stale memory never leaks onto the bus.
        assign data_o = empty_o ? '0 : head_dat;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_d;
        logic [DATA_WIDTH-1:0] dout_q;

        always_comb begin
            dout_d = dout_q;
            if (clr_i) begin
                dout_d = '0;
            end else if (rd_do) begin
                dout_d = head_dat;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_o = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: DEPTH=5 standard-mode instance and DEPTH=16 FWFT instance
// with AF=14/AE=2. A queue scoreboard receives each accepted write and is popped on each
// accepted read; every output is compared against that model one cycle after each edge.
module tb_sync_fifo_flags;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- instance A: DEPTH=5, STD, AF=3, AE=2 -------------
    logic       a_clr = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf_o, a_unf_o;
    logic [2:0] a_level;

    sync_fifo_flags #(
        .DATA_WIDTH (8),
        .DEPTH      (5),
        .MODE       (FIFO_STD)
    ) u_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (a_clr),
        .wr_en_i        (a_wr),
        .data_i         (a_din),
        .rd_en_i        (a_rd),
        .data_o         (a_dout),
        .full_o         (a_full),
        .empty_o        (a_empty),
        .almost_full_o  (a_af),
        .almost_empty_o (a_ae),
        .level_o        (a_level),
        .overflow_o     (a_ovf_o),
        .underflow_o    (a_unf_o)
    );

    // ---------------- instance B: DEPTH=16, FWFT, AF=14, AE=2 ----------
    logic       b_clr = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf_o, b_unf_o;
    logic [4:0] b_level;

    sync_fifo_flags #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .MODE       (FIFO_FWFT),
        .AF_THRESH  (14),
        .AE_THRESH  (2)
    ) u_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (b_clr),
        .wr_en_i        (b_wr),
        .data_i         (b_din),
        .rd_en_i        (b_rd),
        .data_o         (b_dout),
        .full_o         (b_full),
        .empty_o        (b_empty),
        .almost_full_o  (b_af),
        .almost_empty_o (b_ae),
        .level_o        (b_level),
        .overflow_o     (b_ovf_o),
        .underflow_o    (b_unf_o)
    );

    // ---------------- reference models ---------------------------------
    logic [7:0] a_q[$];
    logic [7:0] a_exp_dout = '0;
    logic       a_exp_ovf = 1'b0, a_exp_unf = 1'b0;
    logic [7:0] b_q[$];
    logic       b_exp_ovf = 1'b0, b_exp_unf = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_a(input string tag);
        int lvl;
        lvl = a_q.size();
        chk_eq({tag, ".a.level"}, 32'(a_level), 32'(lvl));
        chk_eq({tag, ".a.full"},  32'(a_full),  32'(lvl == 5));
        chk_eq({tag, ".a.empty"}, 32'(a_empty), 32'(lvl == 0));
        chk_eq({tag, ".a.af"},    32'(a_af),    32'(lvl >= 3));
        chk_eq({tag, ".a.ae"},    32'(a_ae),    32'(lvl <= 2));
        chk_eq({tag, ".a.data"},  32'(a_dout),  32'(a_exp_dout));
        chk_eq({tag, ".a.ovf"},   32'(a_ovf_o), 32'(a_exp_ovf));
        chk_eq({tag, ".a.unf"},   32'(a_unf_o), 32'(a_exp_unf));
    endtask

    task automatic check_b(input string tag);
        int lvl;
        logic [7:0] head;
        lvl = b_q.size();
        head = (lvl > 0) ? b_q[0] : 8'h00;
        chk_eq({tag, ".b.level"}, 32'(b_level), 32'(lvl));
        chk_eq({tag, ".b.full"},  32'(b_full),  32'(lvl == 16));
        chk_eq({tag, ".b.empty"}, 32'(b_empty), 32'(lvl == 0));
        chk_eq({tag, ".b.af"},    32'(b_af),    32'(lvl >= 14));
        chk_eq({tag, ".b.ae"},    32'(b_ae),    32'(lvl <= 2));
        chk_eq({tag, ".b.data"},  32'(b_dout),  32'(head));
        chk_eq({tag, ".b.ovf"},   32'(b_ovf_o), 32'(b_exp_ovf));
        chk_eq({tag, ".b.unf"},   32'(b_unf_o), 32'(b_exp_unf));
    endtask

    // One clock of stimulus on A; model updated from pre-edge state.
    task automatic step_a(input string tag, input logic wr, input logic [7:0] din,
                          input logic rd, input logic clr);
        logic racc, wacc;
        a_wr = wr; a_din = din; a_rd = rd; a_clr = clr;
        if (clr) begin
            a_q.delete();
            a_exp_dout = '0; a_exp_ovf = 1'b0; a_exp_unf = 1'b0;
        end else begin
            racc = rd && (a_q.size() > 0);
            wacc = wr && ((a_q.size() < 5) || racc);
            if (racc) a_exp_dout = a_q.pop_front();
            if (wacc) a_q.push_back(din);
            if (wr && !wacc) a_exp_ovf = 1'b1;
            if (rd && !racc) a_exp_unf = 1'b1;
        end
        @(posedge clk);
        #1;
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
        check_a(tag);
    endtask

    task automatic step_b(input string tag, input logic wr, input logic [7:0] din,
                          input logic rd, input logic clr);
        logic racc, wacc;
        logic [7:0] dummy;
        b_wr = wr; b_din = din; b_rd = rd; b_clr = clr;
        if (clr) begin
            b_q.delete();
            b_exp_ovf = 1'b0; b_exp_unf = 1'b0;
        end else begin
            racc = rd && (b_q.size() > 0);
            wacc = wr && ((b_q.size() < 16) || racc);
            if (racc) dummy = b_q.pop_front();
            if (wacc) b_q.push_back(din);
            if (wr && !wacc) b_exp_ovf = 1'b1;
            if (rd && !racc) b_exp_unf = 1'b1;
        end
        @(posedge clk);
        #1;
        b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
        check_b(tag);
    endtask

    initial begin
        // ---- reset values ----
        #12;
        check_a("reset");
        check_b("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- A: fill to full, drain, pointers wrap ----
        for (int i = 0; i < 5; i++) step_a("fill", 1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step_a("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step_a("refill", 1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);

        // ---- A: full with simultaneous write/read ----
        step_a("full_wr_rd", 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step_a("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk_eq("last_is_aa", 32'(a_dout), 32'h0000_00AA);

        // ---- A: underflow, overflow, flush ----
        step_a("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step_a("fill3", 1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
        step_a("wr_full", 1'b1, 8'h99, 1'b0, 1'b0);
        step_a("clr", 1'b1, 8'h55, 1'b1, 1'b1);
        step_a("post_clr_wr", 1'b1, 8'h66, 1'b0, 1'b0);
        step_a("post_clr_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // ---- B: FWFT fall-through and pop ----
        step_b("fwft_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
        step_b("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // ---- B: threshold sweep, one word per cycle to full ----
        for (int i = 0; i < 16; i++) step_b("thresh", 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        step_b("b_wr_full", 1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step_b("b_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        step_b("b_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // ---- asynchronous reset mid-burst at level 7 ----
        for (int i = 0; i < 7; i++) step_b("burst", 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        step_a("a_pre_rst", 1'b1, 8'h12, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        a_q.delete(); a_exp_dout = '0; a_exp_ovf = 1'b0; a_exp_unf = 1'b0;
        b_q.delete(); b_exp_ovf = 1'b0; b_exp_unf = 1'b0;
        check_a("async_rst");
        check_b("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        step_a("rst_wr", 1'b1, 8'h77, 1'b0, 1'b0);
        step_a("rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        step_b("rst_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
        step_b("rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
